// File: rtl/pipelined_sum_block_pkg.sv
// pipelined_sum_block_pkg: shared op encoding, default geometry and carry helper
package pipelined_sum_block_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_STAGES = 4;
  // Subtraction is a + ~b + !borrow, so the incoming borrow is inverted into a carry
  function automatic logic eff_carry(logic op_sub, logic carry_in);
    return op_sub == OP_ADD ? carry_in : !carry_in;
  endfunction
endpackage

// File: rtl/pipelined_sum_block_if.sv
// pipelined_sum_block_if: operand/result valid-ready bus of the pipelined adder
interface pipelined_sum_block_if
  import pipelined_sum_block_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out;
  logic             overflow;
  modport master (
    output in_valid, a, b, carry_in, op_sub, out_ready,
    input  in_ready, out_valid, out, overflow
  );
  modport slave (
    input  in_valid, a, b, carry_in, op_sub, out_ready,
    output in_ready, out_valid, out, overflow
  );
endinterface

// File: rtl/pipelined_sum_block_sum_segment.sv
// sum_segment: one SEG-bit ripple segment, also exposing the carry into its MSB
module sum_segment
  import pipelined_sum_block_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           carry_in,
  output logic [SEG-1:0] sum,
  output logic           carry_out,
  output logic           carry_msb
);
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + (SEG + 1)'(carry_in);
  // sum bit = a ^ b ^ carry, so the carry into the MSB falls out of the MSB sum bit
  assign carry_msb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
endmodule

// File: rtl/pipelined_sum_block.sv
// pipelined_sum_block: STAGES-deep segmented ripple add/subtract with valid/ready flow control
module pipelined_sum_block
  import pipelined_sum_block_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_sum_block_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;
  logic                             advance;
  logic                             ovf_q;
  logic                             ovf_d;
  logic                             unused_ok;
  logic [STAGES-1:0]                valid_q;
  logic [STAGES-1:0]                carry_q;
  logic [STAGES-1:0]                carry_d;
  logic [STAGES-1:0]                cin;
  logic [STAGES-1:0]                cmsb;
  logic [STAGES-1:0][WIDTH-1:0]     a_q;
  logic [STAGES-1:0][WIDTH-1:0]     b_q;
  logic [STAGES-1:0][WIDTH-1:0]     sum_q;
  logic [STAGES-1:0][WIDTH-1:0]     a_d;
  logic [STAGES-1:0][WIDTH-1:0]     b_d;
  logic [STAGES-1:0][WIDTH-1:0]     sum_in;
  logic [STAGES-1:0][WIDTH-1:0]     sum_d;
  logic [STAGES-1:0][SEG-1:0]       seg_sum;
  assign advance       = !valid_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = advance && rst;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out       = {carry_q[STAGES-1], sum_q[STAGES-1]};
  assign bus.overflow  = ovf_q;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_d[k]    = bus.a;
      assign b_d[k]    = bus.op_sub == OP_SUB ? ~bus.b : bus.b;
      assign cin[k]    = eff_carry(bus.op_sub, bus.carry_in);
      assign sum_in[k] = '0;
    end else begin : g_body
      assign a_d[k]    = a_q[k-1];
      assign b_d[k]    = b_q[k-1];
      assign cin[k]    = carry_q[k-1];
      assign sum_in[k] = sum_q[k-1];
    end
    sum_segment #(.SEG(SEG)) u_seg (
      .a         (a_d[k][k*SEG +: SEG]),
      .b         (b_d[k][k*SEG +: SEG]),
      .carry_in  (cin[k]),
      .sum       (seg_sum[k]),
      .carry_out (carry_d[k]),
      .carry_msb (cmsb[k])
    );
    assign sum_d[k] = (sum_in[k] & ~(WIDTH'({SEG{1'b1}}) << (k * SEG))) |
                      (WIDTH'(seg_sum[k]) << (k * SEG));
  end
  assign ovf_d = cmsb[STAGES-1] ^ carry_d[STAGES-1];
  assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1], cmsb};
  // All stages move in lockstep (bubbles included), hold together on stall, clear on reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_q <= '0;
      carry_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (advance) begin
      valid_q <= STAGES'({valid_q, bus.in_valid});
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
endmodule

// File: tb/tb_pipelined_sum_block.sv
// tb_pipelined_sum_block: randomized scoreboard bench over three adder geometries
module tb_pipelined_sum_block;
  typedef struct {logic [65:0] e; int c;} ent_t;
  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic [2:0]  iv   = '0;
  logic [2:0]  ordy = '1;
  logic [2:0]  ci   = '0;
  logic [2:0]  op   = '0;
  logic [63:0] av[3];
  logic [63:0] bv[3];
  wire  [2:0]  irdy;
  wire  [2:0]  ov;
  wire  [2:0]  ovf;
  wire  [64:0] res[3];
  int          total = 0;
  int          bad = 0;
  int          W[3] = '{32, 8, 64};
  int          S[3] = '{4, 1, 8};
  ent_t        sq[3][$];

  pipelined_sum_block_if #(.WIDTH(32)) m32 ();
  pipelined_sum_block_if #(.WIDTH(8))  m8 ();
  pipelined_sum_block_if #(.WIDTH(64)) m64 ();

  pipelined_sum_block #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst(rst), .bus(m32));
  pipelined_sum_block #(.WIDTH(8),  .STAGES(1)) dut8  (.clk(clk), .rst(rst), .bus(m8));
  pipelined_sum_block #(.WIDTH(64), .STAGES(8)) dut64 (.clk(clk), .rst(rst), .bus(m64));

  assign {m32.in_valid, m32.carry_in, m32.op_sub, m32.out_ready} = {iv[0], ci[0], op[0], ordy[0]};
  assign {m8.in_valid,  m8.carry_in,  m8.op_sub,  m8.out_ready}  = {iv[1], ci[1], op[1], ordy[1]};
  assign {m64.in_valid, m64.carry_in, m64.op_sub, m64.out_ready} = {iv[2], ci[2], op[2], ordy[2]};
  assign m32.a = av[0][31:0];
  assign m32.b = bv[0][31:0];
  assign m8.a  = av[1][7:0];
  assign m8.b  = bv[1][7:0];
  assign m64.a = av[2];
  assign m64.b = bv[2];
  assign {irdy[0], ov[0], ovf[0]} = {m32.in_ready, m32.out_valid, m32.overflow};
  assign {irdy[1], ov[1], ovf[1]} = {m8.in_ready,  m8.out_valid,  m8.overflow};
  assign {irdy[2], ov[2], ovf[2]} = {m64.in_ready, m64.out_valid, m64.overflow};
  assign res[0] = 65'(m32.out);
  assign res[1] = 65'(m8.out);
  assign res[2] = 65'(m64.out);

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on w-bit operands; returns {overflow, out}
  function automatic logic [65:0] model(int w, logic [63:0] a, logic [63:0] b, logic c, logic sub);
    logic [65:0] m, ua, ub, uc, u;
    logic signed [65:0] sa, sb, sr, mx;
    m  = (66'd1 << w) - 66'd1;
    ua = {2'b0, a} & m;
    ub = {2'b0, b} & m;
    uc = {65'd0, c};
    sa = $signed(ua << (66 - w)) >>> (66 - w);
    sb = $signed(ub << (66 - w)) >>> (66 - w);
    sr = sub ? sa - sb - $signed(uc) : sa + sb + $signed(uc);
    mx = 66'sd1 <<< (w - 1);
    u  = sub ? (((ua - ub - uc) & m) | (ua >= ub + uc ? m + 66'd1 : 66'd0)) : ua + ub + uc;
    return {sr >= mx || sr < -mx, u[64:0]};
  endfunction

  task automatic test_reset;
    int lat[3] = '{0, 0, 0};
    rst = 1'b0;
    iv = 3'b111;
    ordy = '1;
    for (int d = 0; d < 3; d++) begin
      av[d] = 64'd1;
      bv[d] = 64'd2;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({irdy[d], ov[d], ovf[d]} !== 3'b000 || res[d] !== 65'd0) begin
        bad++;
        $display("FAIL reset_state[%0d] got rdy/vld/ovf=%b out=%h exp 000 out=0", d, {irdy[d], ov[d], ovf[d]}, res[d]);
      end
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (irdy[d] !== 1'b1) begin
        bad++;
        $display("FAIL first_ready[%0d] got=%b exp=1", d, irdy[d]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    iv = '0;
    for (int n = 1; n <= 12; n++) begin
      for (int d = 0; d < 3; d++)
        if (ov[d] && lat[d] == 0) begin
          lat[d] = n;
          total++;
          if (res[d] !== 65'd3 || ovf[d] !== 1'b0) begin
            bad++;
            $display("FAIL first_result[%0d] got=%h/%b exp=3/0", d, res[d], ovf[d]);
          end
        end
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) begin
      total++;
      if (lat[d] !== S[d]) begin
        bad++;
        $display("FAIL first_latency[%0d] got=%0d exp=%0d", d, lat[d], S[d]);
      end
    end
  endtask

  task automatic test_directed;
    for (int t = 0; t < 3; t++) begin
      logic [64:0] er;
      int n;
      er = t == 0 ? 65'h1_0000_0000 : t == 1 ? 65'h0_8000_0000 : 65'h0_FFFF_FFFE;
      @(negedge clk);
      iv[0] = 1'b1;
      av[0] = t == 0 ? 64'hFFFF_FFFF : t == 1 ? 64'h7FFF_FFFF : 64'd5;
      bv[0] = t == 2 ? 64'd7 : 64'd1;
      ci[0] = 1'b0;
      op[0] = t == 2;
      ordy[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv[0] = 1'b0;
      n = 1;
      while (!ov[0] && n < 20) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (n !== 4) begin
        bad++;
        $display("FAIL directed_latency[%0d] got=%0d exp=4", t, n);
      end
      total++;
      if (res[0] !== er) begin
        bad++;
        $display("FAIL directed_out[%0d] got=%h exp=%h", t, res[0], er);
      end
      total++;
      if (ovf[0] !== (t == 1)) begin
        bad++;
        $display("FAIL directed_ovf[%0d] got=%b exp=%b", t, ovf[0], t == 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    ent_t q[$];
    logic [65:0] held = '0;
    logic hold = 1'b0;
    logic fresh = 1'b1;
    logic acc, pop;
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 100 && got < 8; c++) begin
      @(negedge clk);
      if (ov[0]) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_spurious got=%h exp=none", res[0]);
        end else if ({ovf[0], res[0]} !== q[0].e) begin
          bad++;
          $display("FAIL b2b_result got=%h exp=%h", {ovf[0], res[0]}, q[0].e);
        end
        if (hold) begin
          total++;
          if ({ovf[0], res[0]} !== held) begin
            bad++;
            $display("FAIL b2b_stable got=%h exp=%h", {ovf[0], res[0]}, held);
          end
        end
        held = {ovf[0], res[0]};
      end
      ordy[0] = !(c >= 5 && c < 8);
      if (fresh && sent < 8) begin
        av[0] = {$urandom, $urandom};
        bv[0] = {$urandom, $urandom};
        ci[0] = 1'($urandom);
        op[0] = 1'($urandom);
      end
      iv[0] = sent < 8;
      #1;
      total++;
      if (irdy[0] !== (!ov[0] || ordy[0])) begin
        bad++;
        $display("FAIL b2b_in_ready got=%b exp=%b", irdy[0], !ov[0] || ordy[0]);
      end
      acc = iv[0] && irdy[0];
      pop = ov[0] && ordy[0];
      hold = ov[0] && !ordy[0];
      fresh = acc;
      @(posedge clk);
      if (acc) begin
        q.push_back('{model(32, av[0], bv[0], ci[0], op[0]), c});
        sent++;
      end
      if (pop) begin
        void'(q.pop_front());
        got++;
      end
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    total++;
    if (got !== 8 || q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count got=%0d left=%0d exp=8/0", got, q.size());
    end
  endtask

  task automatic test_reset_inflight;
    logic [65:0] e;
    int stale = 0;
    int n;
    ordy = '1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      iv[0] = 1'b1;
      av[0] = {$urandom, $urandom};
      bv[0] = {$urandom, $urandom};
      ci[0] = 1'($urandom);
      op[0] = 1'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if (ov[0] !== 1'b1) begin
      bad++;
      $display("FAIL inflight_valid got=%b exp=1", ov[0]);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({ov[0], ovf[0]} !== 2'b00 || res[0] !== 65'd0) begin
      bad++;
      $display("FAIL async_clear got vld/ovf=%b out=%h exp 00 out=0", {ov[0], ovf[0]}, res[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ov[0]) stale++;
    end
    total++;
    if (stale !== 0) begin
      bad++;
      $display("FAIL stale_output got=%0d exp=0", stale);
    end
    iv[0] = 1'b1;
    av[0] = {$urandom, $urandom};
    bv[0] = {$urandom, $urandom};
    ci[0] = 1'($urandom);
    op[0] = 1'($urandom);
    e = model(32, av[0], bv[0], ci[0], op[0]);
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    n = 1;
    while (!ov[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 4 || {ovf[0], res[0]} !== e) begin
      bad++;
      $display("FAIL post_reset got lat=%0d val=%h exp lat=4 val=%h", n, {ovf[0], res[0]}, e);
    end
  endtask

  task automatic test_sweep;
    int sent[3] = '{0, 0, 0};
    int got[3] = '{0, 0, 0};
    logic [2:0] acc;
    ordy = '1;
    for (int c = 0; c < 3000 && (got[0] < 1000 || got[1] < 1000 || got[2] < 1000); c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (ov[d]) begin
          total++;
          if (sq[d].size() == 0) begin
            bad++;
            $display("FAIL sweep_spurious[%0d] got=%h exp=none", d, res[d]);
          end else begin
            if ({ovf[d], res[d]} !== sq[d][0].e) begin
              bad++;
              $display("FAIL sweep_result[%0d] got=%h exp=%h", d, {ovf[d], res[d]}, sq[d][0].e);
            end
            total++;
            if (c - sq[d][0].c !== S[d]) begin
              bad++;
              $display("FAIL sweep_latency[%0d] got=%0d exp=%0d", d, c - sq[d][0].c, S[d]);
            end
            void'(sq[d].pop_front());
            got[d]++;
          end
        end
        iv[d] = sent[d] < 1000 && $urandom_range(0, 4) != 0;
        av[d] = $urandom_range(0, 7) == 0 ? '1 : {$urandom, $urandom};
        bv[d] = $urandom_range(0, 7) == 0 ? 64'd1 : {$urandom, $urandom};
        ci[d] = 1'($urandom);
        op[d] = 1'($urandom);
      end
      #1;
      acc = iv & irdy;
      @(posedge clk);
      for (int d = 0; d < 3; d++)
        if (acc[d]) begin
          sq[d].push_back('{model(W[d], av[d], bv[d], ci[d], op[d]), c});
          sent[d]++;
        end
    end
    iv = '0;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (got[d] !== 1000 || sq[d].size() != 0) begin
        bad++;
        $display("FAIL sweep_count[%0d] got=%0d left=%0d exp=1000/0", d, got[d], sq[d].size());
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      av[d] = '0;
      bv[d] = '0;
    end
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_inflight;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_sum_block.md
PIPELINED_SUM_BLOCK -- requirements
Module: pipelined_sum_block

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4, pipeline depth; SHALL be >= 1 and SHALL divide WIDTH exactly, giving segment width SEG = WIDTH/STAGES.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 in_valid  in  1  operand set presented this cycle.
REQ-006 in_ready  out  1  block accepts operands this cycle.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B.
REQ-009 carry_in  in  1  carry (add) or borrow (sub) into bit 0.
REQ-010 op_sub  in  1  0 = add, 1 = subtract.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer accepts result this cycle.
REQ-013 out  out  WIDTH+1  result; bit WIDTH is the final carry.
REQ-014 overflow  out  1  two's-complement signed overflow of the result.

Function
REQ-015 An input SHALL be accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-016 Add SHALL compute a + b + carry_in; sub SHALL compute a + ~b + !carry_in, i.e. a - b - carry_in, with out[WIDTH] = 1 meaning no borrow.
REQ-017 Stage k (0..STAGES-1) SHALL add bits [k*SEG +: SEG] using the carry registered by stage k-1 (stage 0 uses the effective carry from REQ-016); not-yet-processed operand bits and finished sum bits SHALL be carried forward in pipeline registers.
REQ-018 overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1, registered alongside the result.
REQ-019 Latency SHALL be exactly STAGES cycles from acceptance to out_valid with no stall; throughput SHALL be one transaction per cycle.
REQ-020 Each stage SHALL hold a valid bit; out_valid SHALL be the last stage's valid bit.
REQ-021 Stall: advance = !out_valid || out_ready; when advance = 0, all stage registers SHALL hold and in_ready SHALL be 0.
REQ-022 in_ready SHALL equal advance, combinationally, and SHALL be 0 while rst is asserted.
REQ-023 Bubbles SHALL NOT be collapsed: empty stages advance in lockstep with full ones.
REQ-024 out, overflow SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-025 Results SHALL emerge in acceptance order; none SHALL be lost or duplicated under any out_ready pattern.
REQ-026 Simultaneous accept and output in the same cycle SHALL be supported with full throughput.
REQ-027 Operand wrap: 2^WIDTH overflow SHALL appear only in out[WIDTH]; out[WIDTH-1:0] is the modulo result.

Reset
REQ-028 On rst = 0, all stage valid bits, out, and overflow SHALL clear to 0 immediately, without waiting for clk.
REQ-029 Transactions in flight at reset SHALL be discarded; no stale result SHALL appear after deassertion.
REQ-030 First acceptance SHALL be possible on the first rising clk edge after rst returns to 1.

Structure
REQ-031 A shared package SHALL hold the op encoding constants (OP_ADD = 0, OP_SUB = 1) and the default WIDTH/STAGES values.
REQ-032 One sub-module, sum_segment, SHALL implement a single SEG-bit ripple segment (inputs a, b, carry_in; outputs sum, carry_out, carry into MSB), instantiated STAGES times via generate.
REQ-033 Pipeline registers and handshake logic SHALL live in pipelined_sum_block only.

Verification (WIDTH = 32, STAGES = 4 unless stated)
REQ-034 add a=0xFFFFFFFF, b=0x1, cin=0, out_ready=1 -> after 4 cycles out=0x1_00000000, overflow=0.
REQ-035 add a=0x7FFFFFFF, b=0x1, cin=0 -> out=0x0_80000000, overflow=1; sub a=5, b=7, cin=0 -> out=0x0_FFFFFFFE, overflow=0.
REQ-036 8 back-to-back random transactions, out_ready low 3 cycles mid-stream -> in_ready=0 during stall, out held stable, all 8 results in order and equal to the model.
REQ-037 rst asserted mid-cycle with 3 transactions in flight -> out_valid=0 immediately, no output after release, new transaction returns after 4 cycles.
REQ-038 Parameter sweep WIDTH=8/STAGES=1 and WIDTH=64/STAGES=8, 1000 random add/sub ops each -> latency equals STAGES, results match the model.
